// File: rtl/riscv_gprs_file_dump.sv
// RISC-V general-purpose register file: one write port, NRD combinational read ports,
// a hardware clear sweep after reset and a valid/ready stream that dumps every register.
module riscv_gprs_file_dump #(
  parameter int XLEN     = 32,
  parameter int NREGS    = 32,
  parameter int NRD      = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1,
  localparam int AW      = $clog2(NREGS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                reg_write_en,
  input  logic [AW-1:0]       reg_write_dest,
  input  logic [XLEN-1:0]     reg_write_data,
  input  logic [NRD*AW-1:0]   rd_addr,
  output logic [NRD*XLEN-1:0] rd_data,
  output logic                init_busy,
  input  logic                dump_req,
  output logic                dump_valid,
  input  logic                dump_ready,
  output logic [AW-1:0]       dump_idx,
  output logic [XLEN-1:0]     dump_data,
  output logic                dump_done
);

  typedef enum logic [1:0] {
    S_CLEAR,
    S_IDLE,
    S_DUMP
  } state_t;

  localparam logic [AW-1:0] LAST_IDX = AW'(NREGS - 1);

  state_t          state;
  logic [AW-1:0]   ptr;
  logic [XLEN-1:0] mem [NREGS];
  logic            write_ok;
  logic [AW-1:0]   ra;

  assign write_ok = reg_write_en && !(ZERO_REG != 0 && reg_write_dest == '0);

  // Control FSM: all outputs are registered and move together with the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_CLEAR;
      ptr        <= '0;
      init_busy  <= 1'b1;
      dump_valid <= 1'b0;
      dump_done  <= 1'b0;
      dump_idx   <= '0;
    end else begin
      dump_done <= 1'b0;
      case (state)
        S_CLEAR: begin
          ptr <= ptr + 1'b1;
          if (ptr == LAST_IDX) begin
            state     <= S_IDLE;
            init_busy <= 1'b0;
          end
        end
        S_IDLE: begin
          if (dump_req) begin
            state      <= S_DUMP;
            dump_valid <= 1'b1;
            dump_idx   <= '0;
          end
        end
        S_DUMP: begin
          if (dump_ready) begin
            dump_idx <= dump_idx + 1'b1;
            if (dump_idx == LAST_IDX) begin
              state      <= S_IDLE;
              dump_valid <= 1'b0;
              dump_done  <= 1'b1;
            end
          end
        end
        default: state <= S_CLEAR;
      endcase
    end
  end

  // NOTE: the register array has no reset branch; it is zeroed by the CLEAR sweep,
  // which keeps it mappable to plain RAM/flop arrays without a wide reset fan-out.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == S_CLEAR)
        mem[ptr] <= '0;
      else if (write_ok)
        mem[reg_write_dest] <= reg_write_data;
    end
  end

  // Dump beats show the stored value; writes in flight only appear a cycle later.
  assign dump_data = mem[dump_idx];

  // NOTE: combinational logic uses blocking assignments and sets every output to a
  // default first, so no latch is inferred for any read port.
  always_comb begin
    rd_data = '0;
    ra      = '0;
    for (int k = 0; k < NRD; k++) begin
      ra = rd_addr[k*AW +: AW];
      if (state == S_CLEAR || (ZERO_REG != 0 && ra == '0))
        rd_data[k*XLEN +: XLEN] = '0;
      else if (BYPASS != 0 && reg_write_en && reg_write_dest == ra)
        rd_data[k*XLEN +: XLEN] = reg_write_data;
      else
        rd_data[k*XLEN +: XLEN] = mem[ra];
    end
  end

endmodule

// File: tb/tb_riscv_gprs_file_dump.sv
// Directed bench for riscv_gprs_file_dump: table of read/write vectors plus hand-written
// sequences for the clear sweep, the dump stream, back-pressure and reset mid-dump.
module tb_riscv_gprs_file_dump;

  localparam int XLEN  = 32;
  localparam int NREGS = 32;
  localparam int NRD   = 2;
  localparam int AW    = 5;

  logic                clk;
  logic                rst;
  logic                reg_write_en;
  logic [AW-1:0]       reg_write_dest;
  logic [XLEN-1:0]     reg_write_data;
  logic [NRD*AW-1:0]   rd_addr;
  logic [NRD*XLEN-1:0] rd_data;
  logic                init_busy;
  logic                dump_req;
  logic                dump_valid;
  logic                dump_ready;
  logic [AW-1:0]       dump_idx;
  logic [XLEN-1:0]     dump_data;
  logic                dump_done;

  riscv_gprs_file_dump #(
    .XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .ZERO_REG(1), .BYPASS(1)
  ) dut (
    .clk(clk), .rst(rst),
    .reg_write_en(reg_write_en), .reg_write_dest(reg_write_dest),
    .reg_write_data(reg_write_data),
    .rd_addr(rd_addr), .rd_data(rd_data),
    .init_busy(init_busy),
    .dump_req(dump_req), .dump_valid(dump_valid), .dump_ready(dump_ready),
    .dump_idx(dump_idx), .dump_data(dump_data), .dump_done(dump_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic            we;
    logic [AW-1:0]   dest;
    logic [XLEN-1:0] wdata;
    logic [AW-1:0]   a0;
    logic [AW-1:0]   a1;
    logic [XLEN-1:0] exp0;
    logic [XLEN-1:0] exp1;
  } vec_t;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sweep(output int n, output logic saw_done);
    n = 0;
    saw_done = 1'b0;
    while (init_busy === 1'b1 && n < 100) begin
      check("sweep_rd_zero", {32'b0, rd_data}, 64'b0);
      saw_done |= dump_done;
      tick();
      n++;
    end
  endtask

  vec_t            vecs [9];
  logic [XLEN-1:0] m    [NREGS];

  initial begin
    int   n;
    int   c;
    int   exp_idx;
    logic saw_done;
    logic wrote;
    logic finished;

    vecs[0] = '{1'b0, 5'd0,  32'h0,        5'd3,  5'd0,  32'h0,        32'h0};
    vecs[1] = '{1'b1, 5'd5,  32'hDEADBEEF, 5'd5,  5'd0,  32'hDEADBEEF, 32'h0};
    vecs[2] = '{1'b0, 5'd0,  32'h0,        5'd5,  5'd5,  32'hDEADBEEF, 32'hDEADBEEF};
    vecs[3] = '{1'b1, 5'd0,  32'h1234,     5'd0,  5'd5,  32'h0,        32'hDEADBEEF};
    vecs[4] = '{1'b0, 5'd0,  32'h0,        5'd0,  5'd0,  32'h0,        32'h0};
    vecs[5] = '{1'b1, 5'd31, 32'hFFFFFFFF, 5'd31, 5'd30, 32'hFFFFFFFF, 32'h0};
    vecs[6] = '{1'b1, 5'd30, 32'h55,       5'd31, 5'd30, 32'hFFFFFFFF, 32'h55};
    vecs[7] = '{1'b1, 5'd5,  32'h1,        5'd5,  5'd30, 32'h1,        32'h55};
    vecs[8] = '{1'b0, 5'd0,  32'h0,        5'd5,  5'd31, 32'h1,        32'hFFFFFFFF};

    rst = 1'b1; reg_write_en = 1'b0; reg_write_dest = '0; reg_write_data = '0;
    rd_addr = {5'd31, 5'd5}; dump_req = 1'b0; dump_ready = 1'b0;

    // Reset and post-reset clear sweep; a write attempted during the sweep must be lost.
    tick();
    check("reset_state", {60'b0, init_busy, dump_valid, dump_done, 1'b0},
          {60'b0, 1'b1, 1'b0, 1'b0, 1'b0});
    check("reset_idx", {59'b0, dump_idx}, 64'b0);
    rst = 1'b0;
    reg_write_en = 1'b1; reg_write_dest = 5'd3; reg_write_data = 32'hBAD;
    sweep(n, saw_done);
    reg_write_en = 1'b0;
    check("sweep_len", 64'(n), 64'd32);
    check("busy_low", {63'b0, init_busy}, 64'b0);

    // Table-driven read/write vectors: bypass, x0 hardwiring, both ports.
    foreach (vecs[i]) begin
      reg_write_en   = vecs[i].we;
      reg_write_dest = vecs[i].dest;
      reg_write_data = vecs[i].wdata;
      rd_addr        = {vecs[i].a1, vecs[i].a0};
      #1;
      check($sformatf("vec%0d", i), {rd_data[63:32], rd_data[31:0]},
            {vecs[i].exp1, vecs[i].exp0});
      tick();
    end
    reg_write_en = 1'b0;

    // Preload reg[i] = i*3 and dump with dump_ready held high.
    for (int i = 0; i < NREGS; i++) begin
      reg_write_en = 1'b1; reg_write_dest = AW'(i); reg_write_data = 32'(i * 3);
      m[i] = 32'(i * 3);
      tick();
    end
    reg_write_en = 1'b0;
    dump_ready = 1'b1; dump_req = 1'b1;
    tick();
    dump_req = 1'b0;
    for (int i = 0; i < NREGS; i++) begin
      check("dump4_beat", {dump_valid, 26'b0, dump_idx, dump_data},
            {1'b1, 26'b0, 5'(i), 32'(i * 3)});
      tick();
    end
    check("dump4_done", {62'b0, dump_valid, dump_done}, 64'b01);

    // New request accepted in the dump_done cycle; back-pressure 1,0,0,1.
    dump_req = 1'b1;
    tick();
    dump_req = 1'b0;
    check("dump4_done_once", {62'b0, dump_valid, dump_done}, 64'b10);
    exp_idx = 0; wrote = 1'b0; finished = 1'b0; c = 0;
    while (c < 200 && !finished) begin
      dump_ready = (c % 4 == 0) || (c % 4 == 3);
      if (exp_idx == 7 && !wrote && !dump_ready) begin
        reg_write_en = 1'b1; reg_write_dest = 5'd7; reg_write_data = 32'hA5A5A5A5;
      end
      check("dump5_beat", {dump_valid, 26'b0, dump_idx, dump_data},
            {1'b1, 26'b0, 5'(exp_idx), m[exp_idx]});
      tick();
      if (reg_write_en) begin
        m[7] = 32'hA5A5A5A5;
        reg_write_en = 1'b0;
        wrote = 1'b1;
      end
      if (dump_ready) begin
        if (exp_idx == NREGS - 1) finished = 1'b1;
        else exp_idx++;
      end
      c++;
    end
    check("dump5_complete", {62'b0, finished, wrote}, 64'b11);
    check("dump5_done", {62'b0, dump_valid, dump_done}, 64'b01);
    dump_ready = 1'b0;
    tick();
    check("dump5_done_pulse", {63'b0, dump_done}, 64'b0);

    // Reset in the middle of a dump: abort without dump_done, then a fresh sweep.
    dump_ready = 1'b1; dump_req = 1'b1;
    tick();
    dump_req = 1'b0;
    n = 0;
    while (dump_idx !== 5'd10 && n < 40) begin
      tick();
      n++;
    end
    check("dump6_reach10", {59'b0, dump_idx}, 64'd10);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst6_state", {61'b0, dump_valid, dump_done, init_busy}, 64'b001);
    check("rst6_idx", {59'b0, dump_idx}, 64'b0);
    sweep(n, saw_done);
    check("rst6_sweep_len", 64'(n), 64'd32);
    check("rst6_no_done", {63'b0, saw_done}, 64'b0);
    for (int i = 0; i < NREGS / 2; i++) begin
      rd_addr = {5'(i + 16), 5'(i)};
      #1;
      check("rst6_cleared", {32'b0, rd_data}, 64'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
